// File: rtl/sign_pkg.sv
// Shared light-controller definitions: colour codes, FSM states and sizing helpers.
package sign_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  // Width of a side index; a single side still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester search: first set bit of req at or after ptr, wrapping.
module rr_pick import sign_pkg::*; #(
  parameter int NUM_SIDE = 3
) (
  input  logic [NUM_SIDE-1:0]        req,
  input  logic [sel_w(NUM_SIDE)-1:0] ptr,
  output logic                       found,
  output logic [sel_w(NUM_SIDE)-1:0] idx
);

  localparam int SW = sel_w(NUM_SIDE);

  logic [NUM_SIDE-1:0] rot;
  logic [SW-1:0]       off;
  logic [SW:0]         sum;

  // rot[i] is the request of side (ptr+i) mod NUM_SIDE
  assign rot = NUM_SIDE'({req, req} >> ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = NUM_SIDE - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (SW+1)'(NUM_SIDE)) ? SW'(sum - (SW+1)'(NUM_SIDE)) : SW'(sum);
  end

endmodule

// File: rtl/multi_sign_contr.sv
// Highway / multi-side-road light controller: Moore FSM with per-state cycle timer
// and round-robin selection of the side road to serve.
module multi_sign_contr import sign_pkg::*; #(
  parameter int NUM_SIDE       = 3,
  parameter int Y2RDELAY       = 3,
  parameter int R2GDELAY       = 2,
  parameter int MIN_GREEN      = 4,
  parameter int MAX_SIDE_GREEN = 8
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic [NUM_SIDE-1:0]          X,
  output logic [1:0]                   hwy,
  output logic [2*NUM_SIDE-1:0]        cntry,
  output logic [sel_w(NUM_SIDE)-1:0]   sel
);

  localparam int SW   = sel_w(NUM_SIDE);
  localparam int TMAX = max2(max2(Y2RDELAY, R2GDELAY), max2(MIN_GREEN, MAX_SIDE_GREEN));
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TSAT = TW'(TMAX);
  localparam logic [TW-1:0] MG1  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MX1  = TW'(MAX_SIDE_GREEN - 1);
  localparam logic [TW-1:0] Y1   = TW'(Y2RDELAY - 1);
  localparam logic [TW-1:0] R1   = TW'(R2GDELAY - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [SW-1:0] ptr, pick;
  logic          found;

  rr_pick #(.NUM_SIDE(NUM_SIDE)) u_rr (
    .req   (X),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= HG;
      timer <= '0;
      ptr   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      // timer saturates so an idle highway green never wraps
      if (state_nxt != state) timer <= '0;
      else if (timer != TSAT) timer <= timer + 1'b1;
      if (state == HG && state_nxt == HY) sel <= pick;
      if (state == AR2 && state_nxt == HG)
        ptr <= (sel == SW'(NUM_SIDE - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HG:  if (timer >= MG1 && found) state_nxt = HY;
      HY:  if (timer >= Y1) state_nxt = AR1;
      AR1: if (timer >= R1) state_nxt = SG;
      SG:  if ((timer >= MG1 && !X[sel]) || timer >= MX1) state_nxt = SY;
      SY:  if (timer >= Y1) state_nxt = AR2;
      AR2: if (timer >= R1) state_nxt = HG;
      default: state_nxt = HG;
    endcase
  end

  always_comb begin
    hwy   = RED;
    cntry = '0;
    case (state)
      HG: hwy = GREEN;
      HY: hwy = YELLOW;
      SG, SY: begin
        for (int k = 0; k < NUM_SIDE; k++)
          if (sel == SW'(k)) cntry[2*k +: 2] = (state == SG) ? GREEN : YELLOW;
      end
      default: hwy = RED;
    endcase
  end

endmodule

// File: tb/tb_multi_sign_contr.sv
// Scoreboard bench: a phase/duration model predicts the lights every cycle,
// a negedge monitor compares; directed scenarios add run-length checks.
module tb_multi_sign_contr;

  localparam int N = 3, Y2R = 3, R2G = 2, MG = 4, MX = 8;
  localparam logic [1:0] C_RED = 2'd0, C_YEL = 2'd1, C_GRN = 2'd2;

  logic           clock = 1'b0;
  logic           clear = 1'b0;
  logic [N-1:0]   X = '0;
  logic [1:0]     hwy;
  logic [2*N-1:0] cntry;
  logic [1:0]     sel;

  multi_sign_contr #(
    .NUM_SIDE(N), .Y2RDELAY(Y2R), .R2GDELAY(R2G), .MIN_GREEN(MG), .MAX_SIDE_GREEN(MX)
  ) dut (
    .clock(clock), .clear(clear), .X(X), .hwy(hwy), .cntry(cntry), .sel(sel)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]     hwy;
    logic [2*N-1:0] cntry;
    logic [1:0]     sel;
  } exp_t;

  typedef enum int {P_HG, P_HY, P_AR1, P_SG, P_SY, P_AR2} ph_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0, bad = 0;
  ph_t  ph;
  int   cyc, m_sel, m_ptr;
  int   sg_run = 0, last_sg_len = 0;
  int   served_q[$];
  logic mon_green;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    ph = P_HG; cyc = 1; m_sel = 0; m_ptr = 0;
  endfunction

  function automatic void go(input ph_t p);
    ph = p; cyc = 1;
  endfunction

  function automatic void model_step(input logic [N-1:0] x, input logic clr);
    bit hit;
    if (!clr) begin model_reset(); return; end
    case (ph)
      P_HG: if (cyc >= MG && x != 0) begin
        hit = 0;
        for (int k = 0; k < N; k++)
          if (!hit && x[(m_ptr + k) % N]) begin hit = 1; m_sel = (m_ptr + k) % N; end
        go(P_HY);
      end else cyc++;
      P_HY:  if (cyc >= Y2R) go(P_AR1); else cyc++;
      P_AR1: if (cyc >= R2G) go(P_SG);  else cyc++;
      P_SG:  if ((cyc >= MG && !x[m_sel]) || cyc >= MX) go(P_SY); else cyc++;
      P_SY:  if (cyc >= Y2R) go(P_AR2); else cyc++;
      P_AR2: if (cyc >= R2G) begin m_ptr = (m_sel + 1) % N; go(P_HG); end else cyc++;
      default: go(P_HG);
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.hwy = C_RED; e.cntry = '0; e.sel = 2'(m_sel);
    case (ph)
      P_HG: e.hwy = C_GRN;
      P_HY: e.hwy = C_YEL;
      P_SG: e.cntry[2*m_sel +: 2] = C_GRN;
      P_SY: e.cntry[2*m_sel +: 2] = C_YEL;
      default: e.hwy = C_RED;
    endcase
    return e;
  endfunction

  // One clock: model sees the inputs held across the edge, then new inputs go on.
  task automatic tick(input logic [N-1:0] x, input logic clr);
    @(posedge clock);
    model_step(X, clear);
    #1;
    X = x; clear = clr;
    if (!clr) model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic do_reset(input logic [N-1:0] x);
    tick(x, 1'b0); tick(x, 1'b0); tick(x, 1'b1);
    last_sg_len = 0;
    served_q.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("hwy",   32'(hwy),   32'(mon_e.hwy));
      chk("cntry", 32'(cntry), 32'(mon_e.cntry));
      chk("sel",   32'(sel),   32'(mon_e.sel));
    end
    mon_green = 1'b0;
    for (int k = 0; k < N; k++) if (cntry[2*k +: 2] == C_GRN) mon_green = 1'b1;
    if (mon_green) begin
      if (sg_run == 0) served_q.push_back(int'(sel));
      sg_run++;
    end else if (sg_run > 0) begin
      last_sg_len = sg_run;
      sg_run = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] rx;
    int n;
    model_reset();

    // idle: no requests, highway stays green
    do_reset('0);
    repeat (20) tick('0, 1'b1);

    // side 1 held: full sequence with max side green, then ptr moves to 2
    do_reset(3'b010);
    repeat (23) tick(3'b010, 1'b1);
    chk("s2_sg_len", 32'(last_sg_len), 32'(MX));
    chk("s2_served", (served_q.size() > 0) ? served_q[0] : -1, 1);
    n = 0;
    while (served_q.size() < 2 && n < 60) begin tick(3'b110, 1'b1); n++; end
    chk("s2_ptr", (served_q.size() > 1) ? served_q[1] : -1, 2);

    // all sides: round robin 0,1,2,0
    do_reset(3'b111);
    n = 0;
    while (served_q.size() < 4 && n < 200) begin tick(3'b111, 1'b1); n++; end
    chk("s3_count", 32'(served_q.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("s3_order", (served_q.size() > i) ? served_q[i] : -1, i % N);

    // one-cycle pulse on side 0: SG held exactly MIN_GREEN
    do_reset('0);
    repeat (5) tick('0, 1'b1);
    tick(3'b001, 1'b1);
    repeat (30) tick('0, 1'b1);
    chk("s4_sg_len", 32'(last_sg_len), 32'(MG));
    chk("s4_served", (served_q.size() > 0) ? served_q[0] : -1, 0);

    // reset during side yellow
    do_reset(3'b010);
    n = 0;
    while (ph != P_SY && n < 60) begin tick(3'b010, 1'b1); n++; end
    chk("s5_reach_sy", 32'(ph == P_SY), 1);
    chk("s5_pre_sel", 32'(sel), 1);
    tick(3'b010, 1'b0);
    #2;
    chk("s5_rst_hwy", 32'(hwy), 32'(C_GRN));
    chk("s5_rst_cntry", 32'(cntry), 0);
    chk("s5_rst_sel", 32'(sel), 0);
    tick(3'b010, 1'b0);
    tick(3'b010, 1'b1);
    #2;
    chk("s5_hg_hold", 32'(hwy), 32'(C_GRN));
    repeat (3) begin
      tick(3'b010, 1'b1);
      #2;
      chk("s5_hg_hold", 32'(hwy), 32'(C_GRN));
    end
    repeat (4) tick(3'b010, 1'b1);

    // side 2 dropped 6 cycles into SG: SG lasts 7
    do_reset(3'b100);
    n = 0;
    while (!(ph == P_SG && cyc == 6) && n < 80) begin tick(3'b100, 1'b1); n++; end
    chk("s6_reach_sg", 32'(ph == P_SG && cyc == 6), 1);
    tick('0, 1'b1);
    repeat (12) tick('0, 1'b1);
    chk("s6_sg_len", 32'(last_sg_len), 7);

    // random traffic with occasional resets
    rx = '0;
    repeat (500) begin
      if ($urandom_range(0, 5) == 0) rx = N'($urandom_range(0, (1 << N) - 1));
      tick(rx, ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
    end

    @(negedge clock);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
